sd_dat_tx: RTL and testbench
============================

# sd_dat_tx

Parametrised SD host DAT-line write engine: it streams words from the host write FIFO onto 1 or 4 DAT lanes as SD data blocks. Each block carries a start bit, a per-lane CRC16 and an end bit, and the engine waits out card busy between blocks. It sits between the write FIFO and the DAT pads, is armed by the register block, and supports single and multi-block writes with abort. It gates the card clock on FIFO underrun.

## Interface
- FIFO_WIDTH, 32: FIFO word width in bits; must be a multiple of 4.
- BLK_WORDS_W, 8: width of the block-size port (words per block).
- BLK_CNT_W, 16: width of the block-count port.
- clk  in  1  system clock; one DAT bit time per enabled cycle.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- wide_mode  in  1  0 = 1-bit bus (DAT0), 1 = 4-bit bus; sampled at start.
- multi_block  in  1  0 = one block, 1 = blk_cnt blocks; sampled at start.
- blk_words  in  BLK_WORDS_W  FIFO words per block; sampled at start.
- blk_cnt  in  BLK_CNT_W  block count when multi_block = 1; sampled at start.
- abort  in  1  pulse; finish the current block, then go to DONE.
- fifo_data  in  FIFO_WIDTH  show-ahead FIFO head; valid while fifo_empty = 0.
- fifo_empty  in  1  FIFO empty flag.
- fifo_pop  out  1  pops the head; asserted only when fifo_empty = 0.
- dat_in0  in  1  DAT0 pad input, used for busy detection.
- dat_out  out  4  DAT pad outputs.
- dat_oe  out  1  DAT output enable.
- sd_clk_en  out  1  card clock enable; 0 stalls the card clock.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on entry to DONE.
- blocks_sent  out  BLK_CNT_W  number of completed blocks; cleared at start.

## Operation
- Lanes: L = 4 if wide_mode else 1. Unused lanes are driven 1 while dat_oe = 1.
- Bit order: each word goes MSB first. In 4-bit mode, dat_out[3:0] = word[31:28] first. In 1-bit mode, dat_out[0] = word[31] first.
- CRC: one CRC16 per lane, polynomial x^16+x^12+x^5+1, init 0. Each is cleared at block start and sent MSB first on its own lane.
- Buffering: one shift register plus one holding register. The holding register refills from the FIFO whenever it is empty and fifo_empty = 0. The shift register loads from the holding register when its last bit leaves.
- States:
  - IDLE: if start, blk_words != 0 and (!multi_block or blk_cnt != 0), latch the config and go to FILL. Otherwise stay in IDLE.
  - FILL: wait until the holding register is valid, then go to SBIT.
  - SBIT: drive 0 on active lanes with dat_oe = 1 for one cycle, load the shift register, then go to DATA.
  - DATA: shift L bits per cycle for blk_words*FIFO_WIDTH/L cycles, then go to CRC.
  - CRC: 16 cycles, then go to EBIT.
  - EBIT: drive 1 on all lanes for one cycle, then go to TURN.
  - TURN: dat_oe = 0 for 2 cycles, then go to BSY.
  - BSY: wait while dat_in0 = 0.
    - Go to DONE if this was the last block or abort is pending.
    - Otherwise go to FILL.
  - DONE: pulse done for one cycle, then go to IDLE.
- Underrun: in DATA, if the next bit is needed and the holding register is empty, set sd_clk_en = 0 and freeze dat_out, the shift register, the CRCs and the counters. Resume on the cycle the holding register becomes valid. sd_clk_en = 1 in every other case.
- abort is latched in any non-IDLE state. It never truncates a block. In FILL before the first block it goes directly to DONE.
- blocks_sent increments on EBIT.
- Words left in the FIFO after DONE are not popped.

## Timing
- Reset values: dat_out = 4'hF, dat_oe = 0, fifo_pop = 0, sd_clk_en = 1, busy = 0, done = 0, blocks_sent = 0, state = IDLE. All CRC, counter and valid registers are cleared.
- Reset mid-transfer returns to IDLE on the next edge with reset values. No partial block and no done pulse.
- Latency: start at edge n leads to FILL at n+1. With the FIFO non-empty, the holding register loads at n+2 and SBIT is driven in cycle n+2.
- Block length with no stall: 1 + blk_words*FIFO_WIDTH/L + 16 + 1 driven cycles.
  - 4-bit, 128 words: 1042 cycles.
  - 1-bit, 128 words: 4114 cycles.
- fifo_pop is never high with fifo_empty = 1. It pops at most one word per cycle.
- start while busy = 1 is ignored.
- abort together with the last EBIT gives the same result as no abort.

## Test plan
- 1-bit, 1 block, 128 words of 32'hFFFFFFFF: DAT0 shows 0, then 4096 ones, then CRC 16'h7FA1 MSB first, then 1. dat_oe drops 2 cycles later. done pulses once dat_in0 = 1. blocks_sent = 1.
- 4-bit, 1 word 32'h12345678: lanes show start 0, then nibbles 1,2,...,8 in 8 cycles, then 16 CRC cycles matching the reference model, then EBIT. Total 26 driven cycles.
- Underrun: 4-bit, 2 words, second word delayed 5 cycles. sd_clk_en = 0 for exactly 5 cycles with dat_out frozen. Output is otherwise bit-identical to the no-stall case.
- Multi-block: 3 blocks, dat_in0 held low 10 cycles after each block. Next SBIT only after dat_in0 rises. blocks_sent goes 1, 2, 3 and done pulses once.
- Abort: blk_cnt = 5, abort during block 2 DATA. Block 2 completes with valid CRC, no block 3, done pulses, blocks_sent = 2.
- Reset during CRC: next cycle dat_oe = 0, dat_out = 4'hF, busy = 0 and no done pulse. A new start then runs normally.

Source files
------------

// File: rtl/sd_dat_tx.sv
// SD host DAT-line write engine: serialises FIFO words onto 1 or 4 DAT lanes as
// SD data blocks (start bit, payload, per-lane CRC16, end bit) and waits out card busy.
module sd_dat_tx #(
    parameter int FIFO_WIDTH  = 32,
    parameter int BLK_WORDS_W = 8,
    parameter int BLK_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   wide_mode,
    input  logic                   multi_block,
    input  logic [BLK_WORDS_W-1:0] blk_words,
    input  logic [BLK_CNT_W-1:0]   blk_cnt,
    input  logic                   abort,
    input  logic [FIFO_WIDTH-1:0]  fifo_data,
    input  logic                   fifo_empty,
    output logic                   fifo_pop,
    input  logic                   dat_in0,
    output logic [3:0]             dat_out,
    output logic                   dat_oe,
    output logic                   sd_clk_en,
    output logic                   busy,
    output logic                   done,
    output logic [BLK_CNT_W-1:0]   blocks_sent
);

    localparam int SH_W = $clog2(FIFO_WIDTH + 1);
    localparam logic [SH_W-1:0] CYC_1BIT = SH_W'(FIFO_WIDTH);
    localparam logic [SH_W-1:0] CYC_4BIT = SH_W'(FIFO_WIDTH / 4);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_FILL = 4'd1;
    localparam logic [3:0] S_SBIT = 4'd2;
    localparam logic [3:0] S_DATA = 4'd3;
    localparam logic [3:0] S_CRC  = 4'd4;
    localparam logic [3:0] S_EBIT = 4'd5;
    localparam logic [3:0] S_TURN = 4'd6;
    localparam logic [3:0] S_BSY  = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    // CRC16-CCITT (x^16+x^12+x^5+1), one serial bit per call
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    logic [3:0]             r_state;
    logic                   r_wide;
    logic [BLK_WORDS_W-1:0] r_blk_words;
    logic [BLK_CNT_W-1:0]   r_blk_left;
    logic                   r_abort;
    logic                   r_first;
    logic [FIFO_WIDTH-1:0]  r_hold;
    logic                   r_hold_vld;
    logic [BLK_WORDS_W-1:0] r_pop_left;
    logic [FIFO_WIDTH-1:0]  r_shift;
    logic [SH_W-1:0]        r_sh_cnt;
    logic [BLK_WORDS_W-1:0] r_wd_left;
    logic [15:0]            r_crc [4];
    logic [3:0]             r_crc_cnt;
    logic                   r_turn;
    logic [BLK_CNT_W-1:0]   r_blocks_sent;
    logic [3:0]             r_last_out;

    logic                   w_src_sh;
    logic [FIFO_WIDTH-1:0]  w_cur;
    logic                   w_stall;
    logic                   w_adv;
    logic [3:0]             w_dbit;
    logic [3:0]             w_crc_bits;
    logic [SH_W-1:0]        w_cnt_full;
    logic [SH_W-1:0]        w_cnt_now;
    logic [BLK_WORDS_W-1:0] w_wd_after;
    logic                   w_data_last;
    logic                   w_fill_abort;
    logic                   w_pop;
    logic                   w_consume;

    // An empty shift register is equivalent to having just reloaded from the holding register
    assign w_src_sh     = (r_sh_cnt != '0);
    assign w_cur        = w_src_sh ? r_shift : r_hold;
    assign w_stall      = (r_state == S_DATA) && !w_src_sh && !r_hold_vld;
    assign w_adv        = (r_state == S_DATA) && !w_stall;
    assign w_dbit       = r_wide ? w_cur[FIFO_WIDTH-1 -: 4] : {3'b111, w_cur[FIFO_WIDTH-1]};
    assign w_crc_bits   = r_wide ? {r_crc[3][15], r_crc[2][15], r_crc[1][15], r_crc[0][15]}
                                 : {3'b111, r_crc[0][15]};
    assign w_cnt_full   = r_wide ? CYC_4BIT : CYC_1BIT;
    assign w_cnt_now    = w_src_sh ? r_sh_cnt : w_cnt_full;
    assign w_wd_after   = w_src_sh ? r_wd_left : r_wd_left - 1'b1;
    assign w_data_last  = w_adv && (w_cnt_now == SH_W'(1)) && (w_wd_after == '0);
    assign w_fill_abort = (r_state == S_FILL) && r_first && (r_abort || abort);
    assign w_pop        = !r_hold_vld && !fifo_empty && (r_pop_left != '0) && !w_fill_abort &&
                          ((r_state == S_FILL) || (r_state == S_SBIT) || (r_state == S_DATA));
    assign w_consume    = (r_state == S_SBIT) || (w_adv && !w_src_sh);

    always_comb begin
        dat_out = 4'hF;
        dat_oe  = 1'b0;
        case (r_state)
            S_SBIT: begin
                dat_oe  = 1'b1;
                dat_out = r_wide ? 4'h0 : 4'hE;
            end
            S_DATA: begin
                dat_oe  = 1'b1;
                dat_out = w_stall ? r_last_out : w_dbit;
            end
            S_CRC: begin
                dat_oe  = 1'b1;
                dat_out = w_crc_bits;
            end
            S_EBIT: dat_oe = 1'b1;
            default: ;
        endcase
    end

    assign fifo_pop    = w_pop;
    assign sd_clk_en   = !w_stall;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign blocks_sent = r_blocks_sent;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wide        <= 1'b0;
            r_blk_words   <= '0;
            r_blk_left    <= '0;
            r_abort       <= 1'b0;
            r_first       <= 1'b0;
            r_hold_vld    <= 1'b0;
            r_pop_left    <= '0;
            r_sh_cnt      <= '0;
            r_wd_left     <= '0;
            r_crc_cnt     <= '0;
            r_turn        <= 1'b0;
            r_blocks_sent <= '0;
            for (int i = 0; i < 4; i++) r_crc[i] <= '0;
        end else begin
            if (w_pop) begin
                r_hold_vld <= 1'b1;
                r_pop_left <= r_pop_left - 1'b1;
            end else if (w_consume) begin
                r_hold_vld <= 1'b0;
            end
            if (r_state != S_IDLE && abort) r_abort <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start && blk_words != '0 && (!multi_block || blk_cnt != '0)) begin
                        r_wide        <= wide_mode;
                        r_blk_words   <= blk_words;
                        r_blk_left    <= multi_block ? blk_cnt : BLK_CNT_W'(1);
                        r_abort       <= 1'b0;
                        r_first       <= 1'b1;
                        r_pop_left    <= blk_words;
                        r_blocks_sent <= '0;
                        r_state       <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (w_fill_abort)
                        r_state <= S_DONE;
                    else if (r_hold_vld || w_pop)
                        r_state <= S_SBIT;
                end
                S_SBIT: begin
                    r_sh_cnt  <= w_cnt_full;
                    r_wd_left <= r_blk_words - 1'b1;
                    r_first   <= 1'b0;
                    for (int i = 0; i < 4; i++) r_crc[i] <= '0;
                    r_state   <= S_DATA;
                end
                S_DATA: begin
                    if (w_adv) begin
                        r_sh_cnt  <= w_cnt_now - 1'b1;
                        r_wd_left <= w_wd_after;
                        for (int i = 0; i < 4; i++) r_crc[i] <= crc16_step(r_crc[i], w_dbit[i]);
                        if (w_data_last) begin
                            r_crc_cnt <= '0;
                            r_state   <= S_CRC;
                        end
                    end
                end
                S_CRC: begin
                    for (int i = 0; i < 4; i++) r_crc[i] <= {r_crc[i][14:0], 1'b0};
                    r_crc_cnt <= r_crc_cnt + 1'b1;
                    if (r_crc_cnt == 4'd15) r_state <= S_EBIT;
                end
                S_EBIT: begin
                    r_blocks_sent <= r_blocks_sent + 1'b1;
                    r_blk_left    <= r_blk_left - 1'b1;
                    r_turn        <= 1'b0;
                    r_state       <= S_TURN;
                end
                S_TURN: begin
                    r_turn <= 1'b1;
                    if (r_turn) r_state <= S_BSY;
                end
                S_BSY: begin
                    if (dat_in0) begin
                        if (r_blk_left == '0 || r_abort || abort) begin
                            r_state <= S_DONE;
                        end else begin
                            r_pop_left <= r_blk_words;
                            r_state    <= S_FILL;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Payload registers carry no reset; their valid/count companions above do
    always_ff @(posedge clk) begin
        if (w_pop) r_hold <= fifo_data;
        if (r_state == S_SBIT) begin
            r_shift <= r_hold;
        end else if (w_adv) begin
            r_shift    <= r_wide ? (w_cur << 4) : (w_cur << 1);
            r_last_out <= w_dbit;
        end
    end

endmodule

// File: tb/tb_sd_dat_tx.sv
// Scoreboard bench for sd_dat_tx: a block-level reference model queues the expected
// DAT nibbles per driven cycle; a negedge monitor pops and compares.
module tb_sd_dat_tx;
    localparam int W  = 32;
    localparam int BW = 8;
    localparam int BC = 16;

    logic          clk = 1'b0;
    logic          reset, start, wide_mode, multi_block, abort;
    logic [BW-1:0] blk_words;
    logic [BC-1:0] blk_cnt;
    logic [W-1:0]  fifo_data;
    logic          fifo_empty, fifo_pop, dat_in0, dat_oe, sd_clk_en, busy, done;
    logic [3:0]    dat_out;
    logic [BC-1:0] blocks_sent;

    always #5 clk = ~clk;

    sd_dat_tx #(.FIFO_WIDTH(W), .BLK_WORDS_W(BW), .BLK_CNT_W(BC)) dut (
        .clk(clk), .reset(reset), .start(start), .wide_mode(wide_mode),
        .multi_block(multi_block), .blk_words(blk_words), .blk_cnt(blk_cnt),
        .abort(abort), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_pop(fifo_pop), .dat_in0(dat_in0), .dat_out(dat_out), .dat_oe(dat_oe),
        .sd_clk_en(sd_clk_en), .busy(busy), .done(done), .blocks_sent(blocks_sent)
    );

    int         checks = 0;
    int         errors = 0;
    logic [W-1:0] fq[$];
    logic [3:0]   exp_q[$];
    logic         pop_s = 1'b0;
    int         stall_cnt = 0, drv_cnt = 0, done_cnt = 0, gap = 0, last_gap = 0;
    logic [3:0] last_drv = 4'hF;
    logic       prev_oe = 1'b0, prev_oe_c = 1'b0;
    int         busy_len = 0, busy_left = 0;
    int         d0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic upd_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // Reference: expected DAT nibble per driven cycle; CRC as remainder of M(x)*x^16 mod G(x)
    function automatic void push_block(input logic [W-1:0] blk[$], input bit wide);
        logic [16:0] rem [4];
        logic [3:0]  nib;
        int          per;
        per = wide ? W / 4 : W;
        for (int i = 0; i < 4; i++) rem[i] = '0;
        exp_q.push_back(wide ? 4'h0 : 4'hE);
        foreach (blk[k]) begin
            for (int c = 0; c < per; c++) begin
                if (wide) nib = blk[k][W-1-4*c -: 4];
                else      nib = {3'b111, blk[k][W-1-c]};
                exp_q.push_back(nib);
                for (int i = 0; i < 4; i++) begin
                    rem[i] = {rem[i][15:0], nib[i]};
                    if (rem[i][16]) rem[i] = rem[i] ^ 17'h11021;
                end
            end
        end
        for (int z = 0; z < 16; z++)
            for (int i = 0; i < 4; i++) begin
                rem[i] = {rem[i][15:0], 1'b0};
                if (rem[i][16]) rem[i] = rem[i] ^ 17'h11021;
            end
        for (int j = 15; j >= 0; j--)
            exp_q.push_back(wide ? {rem[3][j], rem[2][j], rem[1][j], rem[0][j]} : {3'b111, rem[0][j]});
        exp_q.push_back(4'hF);
    endfunction

    // pat: 0 random, 1 all ones, 2 constant 32'h12345678
    task automatic load(input bit wide, input int nwords, input int nblk, input int nexp, input int pat);
        logic [W-1:0] blk[$];
        logic [W-1:0] w;
        for (int b = 0; b < nblk; b++) begin
            blk.delete();
            for (int i = 0; i < nwords; i++) begin
                w = (pat == 1) ? '1 : (pat == 2) ? 32'h12345678 : $urandom();
                blk.push_back(w);
                fq.push_back(w);
            end
            if (b < nexp) push_block(blk, wide);
        end
        upd_fifo();
    endtask

    task automatic kick(input bit wide, input bit multi, input int nwords, input int nblk);
        @(posedge clk); #2;
        wide_mode = wide; multi_block = multi;
        blk_words = BW'(nwords); blk_cnt = BC'(nblk);
        d0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({nm, "_done_once"}, done_cnt - d0, 1);
        chk({nm, "_idle"}, busy, 1'b0);
        chk({nm, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_oe(input bit rise, input int budget, output bit ok);
        logic pv;
        int   n;
        pv = dat_oe; n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            if (rise ? (!pv && dat_oe) : (pv && !dat_oe)) ok = 1'b1;
            pv = dat_oe;
        end
    endtask

    // FIFO pops take effect just after the edge the DUT used them on
    always @(posedge clk) begin
        if (pop_s) begin
            #1;
            if (fq.size() != 0) void'(fq.pop_front());
            upd_fifo();
        end
    end

    // Card model: after the host releases DAT, hold DAT0 low for turnaround + busy_len cycles
    always @(negedge clk) begin
        if (prev_oe_c && !dat_oe && busy_len > 0) busy_left = busy_len + 2;
        if (busy_left > 0) begin
            dat_in0 = 1'b0;
            busy_left--;
        end else begin
            dat_in0 = 1'b1;
        end
        prev_oe_c = dat_oe;
    end

    always @(negedge clk) begin
        pop_s = fifo_pop;
        if (reset) begin
            prev_oe = 1'b0;
        end else begin
            if (fifo_pop) chk("pop_when_empty", fifo_empty, 1'b0);
            if (!sd_clk_en) begin
                stall_cnt++;
                chk("stall_frozen", dat_out, last_drv);
            end
            if (dat_oe && sd_clk_en) begin
                drv_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_drive: got %0h expected no driven cycle", dat_out);
                end else begin
                    chk("dat_nibble", dat_out, exp_q.pop_front());
                end
                last_drv = dat_out;
            end
            if (dat_oe && !prev_oe) begin
                last_gap = gap;
                gap = 0;
            end
            if (!dat_oe) gap++;
            if (done) done_cnt++;
            prev_oe = dat_oe;
        end
    end

    initial begin
        int   dc0, s0;
        int   n;
        bit   ok;
        logic [W-1:0] w1, w2;
        logic [W-1:0] pair[$];

        reset = 1'b1; start = 1'b0; abort = 1'b0; wide_mode = 1'b0; multi_block = 1'b0;
        blk_words = '0; blk_cnt = '0;
        upd_fifo();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dat_out", dat_out, 4'hF);
        chk("rst_dat_oe", dat_oe, 1'b0);
        chk("rst_pop", fifo_pop, 1'b0);
        chk("rst_clk_en", sd_clk_en, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_blocks", blocks_sent, 0);
        @(posedge clk); #2 reset = 1'b0;

        // Zero-size configurations must not start
        kick(1'b1, 1'b0, 0, 1);
        @(negedge clk); chk("zero_words_ignored", busy, 1'b0);
        kick(1'b1, 1'b1, 4, 0);
        @(negedge clk); chk("zero_blocks_ignored", busy, 1'b0);

        // 1-bit, 128 words of all ones
        load(1'b0, 128, 1, 1, 1);
        dc0 = drv_cnt;
        kick(1'b0, 1'b0, 128, 1);
        wait_done("ones_1bit", 6000);
        chk("ones_1bit_cycles", drv_cnt - dc0, 4114);
        chk("ones_1bit_blocks", blocks_sent, 1);

        // 4-bit, one word, with start latency and a start pulse while busy
        load(1'b1, 1, 1, 1, 2);
        dc0 = drv_cnt;
        @(posedge clk); #2;
        wide_mode = 1'b1; multi_block = 1'b0; blk_words = 1; blk_cnt = 1;
        d0 = done_cnt; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        chk("fill_busy", busy, 1'b1);
        chk("fill_no_oe", dat_oe, 1'b0);
        @(negedge clk);
        chk("sbit_latency_oe", dat_oe, 1'b1);
        @(posedge clk); #2;
        wide_mode = 1'b0; blk_words = 3; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_done("word_4bit", 500);
        chk("word_4bit_cycles", drv_cnt - dc0, 26);

        // Underrun: second word arrives late
        w1 = $urandom(); w2 = $urandom();
        pair.delete(); pair.push_back(w1); pair.push_back(w2);
        push_block(pair, 1'b1);
        fq.push_back(w1); upd_fifo();
        s0 = stall_cnt;
        kick(1'b1, 1'b0, 2, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (sd_clk_en && n < 200);
        chk("underrun_seen", sd_clk_en, 1'b0);
        repeat (4) @(posedge clk);
        #2 fq.push_back(w2); upd_fifo();
        wait_done("underrun", 500);
        chk("underrun_stall_cycles", stall_cnt - s0, 5);

        // Multi-block with card busy between blocks
        busy_len = 10;
        load(1'b1, 4, 3, 3, 0);
        kick(1'b1, 1'b1, 4, 3);
        for (int b = 1; b <= 3; b++) begin
            wait_oe(1'b0, 3000, ok);
            chk("multi_block_end_seen", ok, 1'b1);
            chk("multi_blocks_sent", blocks_sent, b);
        end
        wait_done("multi", 500);
        chk("multi_busy_gap", (last_gap >= busy_len + 3), 1'b1);

        // Abort during the second of five blocks
        busy_len = 3;
        load(1'b1, 8, 5, 2, 0);
        kick(1'b1, 1'b1, 8, 5);
        wait_oe(1'b0, 3000, ok);
        wait_oe(1'b1, 3000, ok);
        chk("abort_blk2_started", ok, 1'b1);
        repeat (10) @(negedge clk);
        @(posedge clk); #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        wait_done("abort", 3000);
        chk("abort_blocks_sent", blocks_sent, 2);
        chk("abort_fifo_left", fq.size(), 24);
        fq.delete(); upd_fifo();
        busy_len = 0;

        // Reset in the middle of the CRC phase
        load(1'b1, 2, 1, 1, 0);
        kick(1'b1, 1'b0, 2, 1);
        n = 0;
        while (exp_q.size() > 10 && n < 500) begin @(negedge clk); n++; end
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_oe", dat_oe, 1'b0);
        chk("midrst_dat", dat_out, 4'hF);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk); #2 reset = 1'b0;
        exp_q.delete(); fq.delete(); upd_fifo();
        repeat (5) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        load(1'b1, 3, 1, 1, 0);
        kick(1'b1, 1'b0, 3, 1);
        wait_done("after_rst", 500);

        // Random single-block transfers
        for (int r = 0; r < 4; r++) begin
            bit wd;
            int nw;
            wd = 1'($urandom_range(0, 1));
            nw = $urandom_range(1, 6);
            busy_len = $urandom_range(0, 5);
            load(wd, nw, 1, 1, 0);
            kick(wd, 1'b0, nw, 1);
            wait_done("random", 2000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
